svf_multichannel: RTL and testbench

SVF_MULTICHANNEL -- requirements
Module: svf_multichannel

---
 rtl/svf_multichannel.sv | 157 +++++++++++++++
 tb/tb_svf_multichannel.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/svf_multichannel.sv
// svf_multichannel: time-multiplexed state-variable filter (HP/LP/BP/notch) over CHANNELS channels.
// Ports: clk, rst (async, active high), sample_clk (frame strobe), in/F/Q1 (packed per channel),
// out_highpass/out_lowpass/out_bandpass/out_notch (clamped, packed like in),
// busy, done (one-cycle), sat (valid with done), overrun (sticky).
module svf_multichannel #(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_clk,
  input  logic [CHANNELS*BITSIZE-1:0]  in,
  input  logic [CHANNELS*20-1:0]       F,
  input  logic [CHANNELS*20-1:0]       Q1,
  output logic [CHANNELS*BITSIZE-1:0]  out_highpass,
  output logic [CHANNELS*BITSIZE-1:0]  out_lowpass,
  output logic [CHANNELS*BITSIZE-1:0]  out_bandpass,
  output logic [CHANNELS*BITSIZE-1:0]  out_notch,
  output logic                         busy,
  output logic                         done,
  output logic                         sat,
  output logic                         overrun
);
  localparam int W  = BITSIZE + 3;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  typedef enum logic [1:0] {IDLE, MQ, MFB, MFH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic prev_q, busy_q, busy_d, done_q, done_d, sat_q, sat_d, overrun_q, overrun_d, start;
  logic signed [W-1:0] lp_q[CHANNELS], lp_d[CHANNELS], bp_q[CHANNELS], bp_d[CHANNELS];
  logic signed [W-1:0] hp_q[CHANNELS], hp_d[CHANNELS], nt_q[CHANNELS], nt_d[CHANNELS];
  logic signed [W-1:0] qb_q, qb_d, p16, p19;
  logic signed [BITSIZE-1:0] in_q[CHANNELS], in_d[CHANNELS];
  logic signed [19:0] f_q[CHANNELS], f_d[CHANNELS], q_q[CHANNELS], q_d[CHANNELS];
  logic signed [19:0] mul_a, mul_b;
  logic [CHANNELS*BITSIZE-1:0] hp_o_q, hp_o_d, lp_o_q, lp_o_d, bp_o_q, bp_o_d, nt_o_q, nt_o_d;
  // A value fits the output width when its top four bits are all equal.
  function automatic logic ovf(input logic signed [W-1:0] v);
    return !(&v[W-1:BITSIZE-1] || ~|v[W-1:BITSIZE-1]);
  endfunction
  function automatic logic [BITSIZE-1:0] clamp(input logic signed [W-1:0] v);
    return ovf(v) ? (v[W-1] ? {1'b1, {(BITSIZE-1){1'b0}}} : {1'b0, {(BITSIZE-1){1'b1}}}) : v[BITSIZE-1:0];
  endfunction
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    done_d = 1'b0;
    sat_d = sat_q;
    lp_d = lp_q;
    bp_d = bp_q;
    hp_d = hp_q;
    nt_d = nt_q;
    qb_d = qb_q;
    in_d = in_q;
    f_d = f_q;
    q_d = q_q;
    hp_o_d = hp_o_q;
    lp_o_d = lp_o_q;
    bp_o_d = bp_o_q;
    nt_o_d = nt_o_q;
    start = !prev_q && sample_clk && !busy_q;
    overrun_d = overrun_q || (!prev_q && sample_clk && busy_q);
    // Single shared multiplier: MQ uses bp*Q1, MFB uses bp*F, MFH uses hp*F.
    mul_a = state_q == MFH ? 20'(hp_q[ch_q]) : 20'(bp_q[ch_q]);
    mul_b = state_q == MQ ? q_q[ch_q] : f_q[ch_q];
    p16 = W'((40'(mul_a) * 40'(mul_b)) >>> 16);
    p19 = W'((40'(mul_a) * 40'(mul_b)) >>> 19);
    if (start) begin
      for (int c = 0; c < CHANNELS; c++) begin
        in_d[c] = in[c*BITSIZE +: BITSIZE];
        f_d[c] = F[c*20 +: 20];
        q_d[c] = Q1[c*20 +: 20];
      end
      state_d = MQ;
      ch_d = '0;
    end else if (state_q == MQ) begin
      qb_d = p16;
      state_d = MFB;
    end else if (state_q == MFB) begin
      lp_d[ch_q] = lp_q[ch_q] + p19;
      hp_d[ch_q] = W'(in_q[ch_q]) - lp_d[ch_q] - qb_q;
      state_d = MFH;
    end else if (state_q == MFH) begin
      bp_d[ch_q] = bp_q[ch_q] + p19;
      nt_d[ch_q] = hp_q[ch_q] + lp_q[ch_q];
      done_d = ch_q == CW'(CHANNELS - 1);
      state_d = done_d ? IDLE : MQ;
      ch_d = done_d ? ch_q : ch_q + CW'(1);
    end
    // Outputs are taken from the next-state values so the last channel lands in the same update.
    if (done_d) begin
      sat_d = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        hp_o_d[c*BITSIZE +: BITSIZE] = clamp(hp_d[c]);
        lp_o_d[c*BITSIZE +: BITSIZE] = clamp(lp_d[c]);
        bp_o_d[c*BITSIZE +: BITSIZE] = clamp(bp_d[c]);
        nt_o_d[c*BITSIZE +: BITSIZE] = clamp(nt_d[c]);
        sat_d = sat_d | ovf(hp_d[c]) | ovf(lp_d[c]) | ovf(bp_d[c]) | ovf(nt_d[c]);
      end
    end
    // busy stays high through the done cycle so an edge there counts as overrun.
    busy_d = state_d != IDLE || done_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q <= '0;
      prev_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sat_q <= 1'b0;
      overrun_q <= 1'b0;
      qb_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        lp_q[c] <= '0;
        bp_q[c] <= '0;
        hp_q[c] <= '0;
        nt_q[c] <= '0;
        in_q[c] <= '0;
        f_q[c] <= '0;
        q_q[c] <= '0;
      end
      hp_o_q <= '0;
      lp_o_q <= '0;
      bp_o_q <= '0;
      nt_o_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      prev_q <= sample_clk;
      busy_q <= busy_d;
      done_q <= done_d;
      sat_q <= sat_d;
      overrun_q <= overrun_d;
      qb_q <= qb_d;
      lp_q <= lp_d;
      bp_q <= bp_d;
      hp_q <= hp_d;
      nt_q <= nt_d;
      in_q <= in_d;
      f_q <= f_d;
      q_q <= q_d;
      hp_o_q <= hp_o_d;
      lp_o_q <= lp_o_d;
      bp_o_q <= bp_o_d;
      nt_o_q <= nt_o_d;
    end
  end
  assign out_highpass = hp_o_q;
  assign out_lowpass = lp_o_q;
  assign out_bandpass = bp_o_q;
  assign out_notch = nt_o_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sat = sat_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_svf_multichannel.sv
// tb_svf_multichannel: directed table-driven bench for svf_multichannel.
module tb_svf_multichannel;
  localparam int B = 16, C = 4;
  logic clk = 0, rst = 1, sample_clk = 0;
  logic [C*B-1:0] in, out_highpass, out_lowpass, out_bandpass, out_notch;
  logic [C*20-1:0] F, Q1;
  logic busy, done, sat, overrun;
  int checks = 0, passed = 0;
  svf_multichannel #(.BITSIZE(B), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .in(in), .F(F), .Q1(Q1),
    .out_highpass(out_highpass), .out_lowpass(out_lowpass), .out_bandpass(out_bandpass),
    .out_notch(out_notch), .busy(busy), .done(done), .sat(sat), .overrun(overrun));
  always #5 clk = ~clk;
  typedef struct {
    bit rst_first;
    bit chk0;
    int in0, f0, q0;
    int hp, lp, bp, nt;
    bit sat;
  } vec_t;
  vec_t vt[12];
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic longint ch0(input logic [C*B-1:0] bus);
    return longint'($signed(bus[B-1:0]));
  endfunction
  task automatic set_in(input int i0, input int f0, input int q0);
    in = {48'd0, 16'(i0)};
    F = {20'h20000, 20'h20000, 20'h20000, 20'(f0)};
    Q1 = {20'h10000, 20'h10000, 20'h10000, 20'(q0)};
  endtask
  task automatic do_reset(input bit sclk);
    @(negedge clk);
    sample_clk = sclk;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  task automatic wait_done(input int from, output int lat);
    lat = -1;
    for (int n = from; n <= 40 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (done) lat = n + 1;
    end
  endtask
  task automatic run_frame(output int lat);
    @(negedge clk);
    sample_clk = 1;
    @(posedge clk);
    #1;
    chk("busy_rise", busy, 1);
    @(negedge clk);
    sample_clk = 0;
    wait_done(1, lat);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("busy_fall", busy, 0);
  endtask
  task automatic quiet(input string name);
    bit seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen |= done | busy;
    end
    chk(name, seen, 0);
  endtask
  task automatic check_ch0(input string tag, input int hp, input int lp, input int bp, input int nt);
    chk({tag, "_hp"}, ch0(out_highpass), hp);
    chk({tag, "_lp"}, ch0(out_lowpass), lp);
    chk({tag, "_bp"}, ch0(out_bandpass), bp);
    chk({tag, "_notch"}, ch0(out_notch), nt);
  endtask
  initial begin
    int lat;
    vt[0] = '{1, 1, 1000, 'h20000, 'h10000, 1000, 0, 250, 1000, 0};
    vt[1] = '{0, 1, 1000, 'h20000, 'h10000, 688, 62, 422, 750, 0};
    for (int i = 2; i < 10; i++) vt[i] = '{0, 0, 1000, 'h20000, 'h10000, 0, 0, 0, 0, 0};
    vt[10] = '{1, 1, 32767, 'h7FFFF, 'hE0000, 32767, 0, 32766, 32767, 0};
    vt[11] = '{0, 1, 32767, 'h7FFFF, 'hE0000, 32767, 32765, 32767, 32767, 1};
    set_in(1000, 'h20000, 'h10000);
    sample_clk = 1;
    repeat (2) @(negedge clk);
    chk("rst_hp", out_highpass, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    chk("rst_overrun", overrun, 0);
    rst = 0;
    quiet("held_high_no_start");
    for (int i = 0; i < 12; i++) begin
      if (vt[i].rst_first) do_reset(0);
      set_in(vt[i].in0, vt[i].f0, vt[i].q0);
      run_frame(lat);
      chk($sformatf("v%0d_latency", i), lat, 13);
      chk($sformatf("v%0d_others_zero", i),
          |{out_highpass[C*B-1:B], out_lowpass[C*B-1:B], out_bandpass[C*B-1:B], out_notch[C*B-1:B]}, 0);
      if (vt[i].chk0) begin
        check_ch0($sformatf("v%0d", i), vt[i].hp, vt[i].lp, vt[i].bp, vt[i].nt);
        chk($sformatf("v%0d_sat", i), sat, vt[i].sat);
      end
    end
    do_reset(0);
    chk("ovr_clear", overrun, 0);
    set_in(1000, 'h20000, 'h10000);
    @(negedge clk);
    sample_clk = 1;
    @(posedge clk);
    @(negedge clk);
    sample_clk = 0;
    set_in(5000, 'h7FFFF, 'h10000);
    repeat (4) @(negedge clk);
    sample_clk = 1;
    @(negedge clk);
    sample_clk = 0;
    wait_done(6, lat);
    chk("ovr_latency", lat, 13);
    chk("ovr_set", overrun, 1);
    check_ch0("ovr", 1000, 0, 250, 1000);
    set_in(1000, 'h20000, 'h10000);
    @(posedge clk);
    run_frame(lat);
    check_ch0("ovr_f2", 688, 62, 422, 750);
    chk("ovr_sticky", overrun, 1);
    do_reset(0);
    @(negedge clk);
    sample_clk = 1;
    @(posedge clk);
    @(negedge clk);
    sample_clk = 0;
    wait_done(1, lat);
    chk("donecyc_latency", lat, 13);
    @(negedge clk);
    sample_clk = 1;
    @(posedge clk);
    #1;
    chk("donecyc_overrun", overrun, 1);
    chk("donecyc_busy", busy, 0);
    quiet("donecyc_no_frame");
    @(negedge clk);
    sample_clk = 0;
    do_reset(0);
    run_frame(lat);
    check_ch0("pre_abort", 1000, 0, 250, 1000);
    @(negedge clk);
    sample_clk = 1;
    @(posedge clk);
    @(negedge clk);
    sample_clk = 0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("abort_hp", ch0(out_highpass), 0);
    chk("abort_bp", ch0(out_bandpass), 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    quiet("abort_no_done");
    run_frame(lat);
    chk("abort_next_latency", lat, 13);
    check_ch0("abort_next", 1000, 0, 250, 1000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
